// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch stage and control unit: FSM states,
// next-PC select codes, instruction field positions and target-forming helpers.
package mips_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 26;
    localparam int FUNC_MSB     = 5;
    localparam int FUNC_LSB     = 0;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    // Word offset of a branch: sign-extended immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] target);
        return {pc4[31:28], target, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC adder and select mux; only the low 26 instruction bits matter here,
// since immediate and jump target both live inside them.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc4_i,
    input  logic [25:0] inst_i,
    input  logic [1:0]  pcsrc_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] branch_pc_s;
    logic [31:0] jump_pc_s;

    // Branch carry out of bit 31 is discarded by the 32-bit sum.
    always_comb begin
        branch_pc_s = pc4_i + branch_offset(inst_i[IMM16_MSB:IMM16_LSB]);
        jump_pc_s   = jump_target(pc4_i, inst_i[TARGET26_MSB:TARGET26_LSB]);
        next_pc_o   = pc4_i;
        case (pcsrc_i)
            PCSRC_BR: next_pc_o = branch_pc_s;
            PCSRC_J:  next_pc_o = jump_pc_s;
            default:  next_pc_o = pc4_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds PC, fetches one instruction per step over req/ack,
// waits for Commit, then advances PC by the control unit's Pcsrc choice.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    output logic             Imem_req,
    output logic [31:0]      Imem_addr,
    input  logic             Imem_ack,
    input  logic [31:0]      Imem_rdata,
    input  logic             Commit,
    input  logic [1:0]       Pcsrc,
    output logic [31:0]      Inst,
    output logic [5:0]       Op,
    output logic [5:0]       Func,
    output logic             Inst_valid,
    output logic [31:0]      Pc,
    output logic [31:0]      Pc4,
    output logic [CNT_W-1:0] Icount
);

    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,  state_d;
    logic [31:0]      pc_q,     pc_d;
    logic [31:0]      inst_q,   inst_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic             req_q;
    logic             valid_q;
    logic [31:0]      pc4_s;
    logic [31:0]      next_pc_s;

    assign pc4_s = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc4_i     (pc4_s),
        .inst_i    (inst_q[25:0]),
        .pcsrc_i   (Pcsrc),
        .next_pc_o (next_pc_s)
    );

    // Step sequencing: ack only matters in FETCH, Commit only in EXEC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        icount_d = icount_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (Imem_ack) begin
                    inst_d  = Imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (Commit) begin
                    pc_d     = next_pc_s;
                    icount_d = icount_q + CNT_ONE;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they never glitch.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            inst_q   <= 32'h0000_0000;
            icount_q <= {CNT_W{1'b0}};
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            icount_q <= icount_d;
            req_q    <= (state_d == ST_FETCH);
            valid_q  <= (state_d == ST_EXEC);
        end
    end

    assign Imem_req   = req_q;
    assign Imem_addr  = pc_q;
    assign Inst       = inst_q;
    assign Op         = inst_q[OP_MSB:OP_LSB];
    assign Func       = inst_q[FUNC_MSB:FUNC_LSB];
    assign Inst_valid = valid_q;
    assign Pc         = pc_q;
    assign Pc4        = pc4_s;
    assign Icount     = icount_q;

endmodule
